// File: rtl/correlator_packetizer.sv
// correlator_packetizer: on an integration tick, snapshots timestamp + correlator
// counters, pulses 'clear' to the array, then streams header/payload/footer to the
// UART TX stage as uppercase ASCII hex chars terminated by CR, or as raw bytes.
module correlator_packetizer #(
  parameter int unsigned PAYLOAD_SIZE = 1152,
  parameter int unsigned HEADER_SIZE  = 64,
  parameter int unsigned FOOTER_SIZE  = 64,
  parameter bit          BINARY       = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    trigger,
  input  logic [63:0]             timestamp,
  input  logic [PAYLOAD_SIZE-1:0] pulses,
  output logic                    clear,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned STEP     = BINARY ? 8 : 4;
  localparam int unsigned FW       = HEADER_SIZE + PAYLOAD_SIZE + FOOTER_SIZE;
  localparam int unsigned H_UNITS  = HEADER_SIZE / STEP;
  localparam int unsigned P_UNITS  = PAYLOAD_SIZE / STEP;
  localparam int unsigned TOTAL    = FW / STEP;
  localparam int unsigned CW       = $clog2(TOTAL) + 1;

  localparam logic [CW-1:0] LAST_HDR = CW'(H_UNITS - 1);
  localparam logic [CW-1:0] LAST_PAY = CW'(H_UNITS + P_UNITS - 1);
  localparam logic [CW-1:0] LAST_ALL = CW'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_HEADER,
    S_PAYLOAD,
    S_FOOTER,
    S_TERM
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          clear_q, clear_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   packet_count_q, packet_count_d;
  logic [31:0]   checksum_q, checksum_d;
  logic [3:0]    hi_nib_q, hi_nib_d;

  logic          accept;
  logic          pay_lo;
  logic [7:0]    pay_byte;
  logic [31:0]   cs_acc;

  // Character presented for the unit at the top of the frame.
  function automatic logic [7:0] to_char(input logic [7:0] top);
    if (BINARY) begin
      return top;
    end else if (top[7:4] < 4'd10) begin
      return 8'h30 + {4'h0, top[7:4]};
    end else begin
      return 8'h37 + {4'h0, top[7:4]};
    end
  endfunction

  // Next-state logic: frame is a left-shifting snapshot; the footer overwrites its
  // top bits at the moment the last payload unit is accepted.
  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    cnt_d          = cnt_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    clear_d        = 1'b0;
    busy_d         = busy_q;
    overrun_d      = 1'b0;
    packet_count_d = packet_count_q;
    checksum_d     = checksum_q;
    hi_nib_d       = hi_nib_q;

    accept   = tx_valid_q && tx_ready;
    // In hex mode a payload byte is complete when its low-nibble char goes out.
    pay_lo   = BINARY ? 1'b1 : cnt_q[0];
    pay_byte = BINARY ? frame_q[FW-1 -: 8] : {hi_nib_q, frame_q[FW-1 -: 4]};
    cs_acc   = checksum_q + {24'h0, pay_byte};

    if (trigger && enable && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger && enable) begin
          state_d = S_LATCH;
          clear_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_LATCH: begin
        frame_d    = {timestamp, pulses, {FOOTER_SIZE{1'b0}}};
        checksum_d = '0;
        cnt_d      = '0;
        // First char is taken straight from the input so it is valid one cycle later.
        tx_data_d  = to_char(timestamp[63 -: 8]);
        tx_valid_d = 1'b1;
        state_d    = S_HEADER;
      end

      S_HEADER, S_PAYLOAD, S_FOOTER: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          frame_d    = frame_q << STEP;
          hi_nib_d   = frame_q[FW-1 -: 4];
          cnt_d      = cnt_q + CW'(1);
          if ((state_q == S_PAYLOAD) && pay_lo) begin
            checksum_d = cs_acc;
          end
          if ((state_q == S_HEADER) && (cnt_q == LAST_HDR)) begin
            state_d = S_PAYLOAD;
          end
          if ((state_q == S_PAYLOAD) && (cnt_q == LAST_PAY)) begin
            state_d = S_FOOTER;
            frame_d = {packet_count_q, cs_acc, {(FW - FOOTER_SIZE){1'b0}}};
          end
          if ((state_q == S_FOOTER) && (cnt_q == LAST_ALL)) begin
            if (BINARY) begin
              state_d        = S_IDLE;
              busy_d         = 1'b0;
              packet_count_d = packet_count_q + 32'd1;
            end else begin
              state_d = S_TERM;
            end
          end
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = to_char(frame_q[FW-1 -: 8]);
        end
      end

      S_TERM: begin
        if (accept) begin
          tx_valid_d     = 1'b0;
          state_d        = S_IDLE;
          busy_d         = 1'b0;
          packet_count_d = packet_count_q + 32'd1;
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h0D;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      frame_q        <= '0;
      cnt_q          <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      clear_q        <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      packet_count_q <= '0;
      checksum_q     <= '0;
      hi_nib_q       <= '0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      cnt_q          <= cnt_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      clear_q        <= clear_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      packet_count_q <= packet_count_d;
      checksum_q     <= checksum_d;
      hi_nib_q       <= hi_nib_d;
    end
  end

  assign clear    = clear_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_correlator_packetizer.sv
// Bench for correlator_packetizer: a hex instance (index 0) and a binary instance
// (index 1) share trigger/enable/reset/data inputs; each has its own tx_ready.
module tb_correlator_packetizer;

  localparam int unsigned PS = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          trigger;
  logic [63:0]   timestamp;
  logic [PS-1:0] pulses;
  logic          clear    [2];
  logic [7:0]    tx_data  [2];
  logic          tx_valid [2];
  logic          tx_ready [2];
  logic          busy     [2];
  logic          overrun  [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (per instance)
  logic [7:0]  exp_s [2][64];
  int          exp_len [2];
  int          exp_ptr [2];
  bit          m_busy [2];
  bit          latch_pend [2];
  logic [31:0] m_pc [2];
  bit          e_clear [2];
  bit          e_ovr [2];
  bit          e_busy [2];
  bit          must_inv [2];
  bit          first [2];
  bit          hold_v [2];
  bit          gap [2];
  bit          resume [2];
  logic [7:0]  hold_d [2];
  logic [7:0]  cap [2][64];
  int          cap_len [2];
  int          clr_seen [2];
  int          ovr_seen [2];
  bit          chk_en;
  int          rmode;

  correlator_packetizer #(
    .PAYLOAD_SIZE(PS), .HEADER_SIZE(64), .FOOTER_SIZE(64), .BINARY(1'b0)
  ) u_hex (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .timestamp(timestamp), .pulses(pulses), .clear(clear[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0]), .overrun(overrun[0])
  );

  correlator_packetizer #(
    .PAYLOAD_SIZE(PS), .HEADER_SIZE(64), .FOOTER_SIZE(64), .BINARY(1'b1)
  ) u_bin (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .timestamp(timestamp), .pulses(pulses), .clear(clear[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .busy(busy[1]), .overrun(overrun[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  // Expected packet: 8 timestamp bytes, 6 payload bytes, packet count, byte sum.
  task automatic build(input int i);
    logic [7:0]  b [22];
    logic [31:0] cs;
    cs = '0;
    for (int k = 0; k < 8; k++) b[k] = timestamp[63-8*k -: 8];
    for (int k = 0; k < 6; k++) begin
      b[8+k] = pulses[PS-1-8*k -: 8];
      cs = cs + 32'(b[8+k]);
    end
    for (int k = 0; k < 4; k++) begin
      b[14+k] = m_pc[i][31-8*k -: 8];
      b[18+k] = cs[31-8*k -: 8];
    end
    if (i == 0) begin
      for (int k = 0; k < 22; k++) begin
        exp_s[0][2*k]   = hexc(b[k][7:4]);
        exp_s[0][2*k+1] = hexc(b[k][3:0]);
      end
      exp_s[0][44] = 8'h0D;
      exp_len[0]   = 45;
    end else begin
      for (int k = 0; k < 22; k++) exp_s[1][k] = b[k];
      exp_len[1] = 22;
    end
    exp_ptr[i] = 0;
    cap_len[i] = 0;
  endtask

  task automatic compare_loop();
    bit active;
    bit was_busy;
    bit done;
    bit acc;
    forever begin
      @(negedge clk);
      active = chk_en;
      if (reset) chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (active) begin
          chk("clear", 64'(clear[i]), 64'(e_clear[i]));
          chk("overrun", 64'(overrun[i]), 64'(e_ovr[i]));
          chk("busy", 64'(busy[i]), 64'(e_busy[i]));
          if (must_inv[i] || gap[i] || !m_busy[i]) chk("valid_low", 64'(tx_valid[i]), 64'd0);
          if (first[i]) chk("first_char", {tx_valid[i], tx_data[i]}, {1'b1, exp_s[i][0]});
          if (hold_v[i]) chk("hold_stable", {tx_valid[i], tx_data[i]}, {1'b1, hold_d[i]});
          if (resume[i]) chk("no_long_bubble", 64'(tx_valid[i]), 64'd1);
          if (clear[i] === 1'b1) clr_seen[i]++;
          if (overrun[i] === 1'b1) ovr_seen[i]++;
        end
        if (chk_en) begin
          if (reset) begin
            e_clear[i] = 0; e_ovr[i] = 0; e_busy[i] = 0; must_inv[i] = 1;
            m_busy[i] = 0; latch_pend[i] = 0; m_pc[i] = '0; first[i] = 0;
            hold_v[i] = 0; gap[i] = 0; resume[i] = 0;
          end else begin
            must_inv[i] = 0;
            first[i]    = 0;
            if (latch_pend[i]) begin
              build(i);
              latch_pend[i] = 0;
              first[i]      = 1;
            end
            acc       = tx_valid[i] && tx_ready[i];
            resume[i] = gap[i];
            gap[i]    = 0;
            hold_v[i] = tx_valid[i] && !tx_ready[i];
            hold_d[i] = tx_data[i];
            done      = 0;
            was_busy  = m_busy[i];
            if (acc) begin
              if (m_busy[i] && exp_ptr[i] < exp_len[i]) begin
                chk("tx_byte", 64'(tx_data[i]), 64'(exp_s[i][exp_ptr[i]]));
                if (cap_len[i] < 64) begin
                  cap[i][cap_len[i]] = tx_data[i];
                  cap_len[i]++;
                end
                exp_ptr[i]++;
                if (exp_ptr[i] == exp_len[i]) done = 1;
                else gap[i] = 1;
              end else begin
                chk("spurious_accept", 64'd1, 64'd0);
              end
            end
            if (done) begin
              m_busy[i] = 0;
              m_pc[i]   = m_pc[i] + 32'd1;
            end
            e_clear[i] = 0;
            e_ovr[i]   = 0;
            if (trigger && enable) begin
              if (was_busy) e_ovr[i] = 1;
              else begin
                e_clear[i]    = 1;
                m_busy[i]     = 1;
                latch_pend[i] = 1;
              end
            end
            e_busy[i] = m_busy[i];
          end
        end
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        tx_ready[i] = (rmode == 1) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while ((m_busy[0] || m_busy[1]) && k < bound) begin
      cyc(1);
      k++;
    end
    if (k >= bound) chk("idle_timeout", 64'd1, 64'd0);
    cyc(2);
  endtask

  // Hex capture against the hand-written packet for the default stimulus, count 0.
  task automatic check_hex_lit(input string nm, input int n);
    string lit;
    lit = "0123456789ABCDEF";
    lit = {lit, "000001000002"};
    lit = {lit, "0000000000000003"};
    if (n == 45) chk({nm, "_len"}, 64'(cap_len[0]), 64'd45);
    for (int k = 0; k < n && k < 44; k++) chk({nm, "_char"}, 64'(cap[0][k]), 64'(lit[k]));
    if (n == 45) chk({nm, "_cr"}, 64'(cap[0][44]), 64'h0D);
  endtask

  initial begin
    int c0, c1, o0, o1, k;
    chk_en = 0;
    rmode  = 1;
    for (int i = 0; i < 2; i++) begin
      tx_ready[i] = 1'b1; m_busy[i] = 0; latch_pend[i] = 0; m_pc[i] = '0;
      exp_len[i] = 0; exp_ptr[i] = 0; cap_len[i] = 0; clr_seen[i] = 0; ovr_seen[i] = 0;
      e_clear[i] = 0; e_ovr[i] = 0; e_busy[i] = 0; must_inv[i] = 0; first[i] = 0;
      hold_v[i] = 0; gap[i] = 0; resume[i] = 0; hold_d[i] = '0;
    end
    reset     = 1'b1;
    enable    = 1'b0;
    trigger   = 1'b0;
    timestamp = 64'h0123456789ABCDEF;
    pulses    = 48'h000001_000002;
    fork
      compare_loop();
      ready_loop();
    join_none

    cyc(3);
    for (int i = 0; i < 2; i++) begin
      chk("reset_tx_data", 64'(tx_data[i]), 64'd0);
      chk("reset_tx_valid", 64'(tx_valid[i]), 64'd0);
      chk("reset_busy", 64'(busy[i]), 64'd0);
      chk("reset_clear", 64'(clear[i]), 64'd0);
    end
    reset = 1'b0;
    enable = 1'b1;
    cyc(2);

    // 1/2: basic packet, both modes, ready held high
    pulse_trigger();
    wait_idle(400);
    check_hex_lit("t1", 45);
    chk("t2_len", 64'(cap_len[1]), 64'd22);
    chk("t2_foot", {cap[1][18], cap[1][19], cap[1][20], cap[1][21]}, 64'h00000003);

    pulse_trigger();
    wait_idle(400);
    chk("t2_pc1", {cap[1][14], cap[1][15], cap[1][16], cap[1][17]}, 64'h00000001);

    // 3: random back-pressure
    rmode = 2;
    pulse_trigger();
    wait_idle(3000);
    rmode = 1;
    cyc(2);
    check_hex_lit("t3", 28);

    // 4: second trigger five cycles after the first
    c0 = clr_seen[0]; c1 = clr_seen[1]; o0 = ovr_seen[0]; o1 = ovr_seen[1];
    pulse_trigger();
    cyc(4);
    pulse_trigger();
    wait_idle(400);
    chk("t4_clear_hex", 64'(clr_seen[0] - c0), 64'd1);
    chk("t4_clear_bin", 64'(clr_seen[1] - c1), 64'd1);
    chk("t4_ovr_hex", 64'(ovr_seen[0] - o0), 64'd1);
    chk("t4_ovr_bin", 64'(ovr_seen[1] - o1), 64'd1);

    // 5: reset after 10 chars, then a fresh packet with count 0
    pulse_trigger();
    cyc(2);
    k = 0;
    while (exp_ptr[0] < 10 && k < 200) begin
      cyc(1);
      k++;
    end
    if (k >= 200) chk("t5_timeout", 64'd1, 64'd0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t5_valid_after_reset", 64'(tx_valid[0]), 64'd0);
    cyc(2);
    pulse_trigger();
    wait_idle(400);
    check_hex_lit("t5", 45);
    chk("t5_pc0_bin", {cap[1][14], cap[1][15], cap[1][16], cap[1][17]}, 64'h00000000);

    // 6: all-ones payload checksum; trigger ignored when disabled
    pulses = {PS{1'b1}};
    pulse_trigger();
    wait_idle(400);
    chk("t6_checksum", {cap[1][18], cap[1][19], cap[1][20], cap[1][21]}, 64'h000005FA);
    c0 = clr_seen[0]; o0 = ovr_seen[0]; c1 = clr_seen[1];
    enable = 1'b0;
    pulse_trigger();
    cyc(6);
    chk("t6_dis_clear", 64'(clr_seen[0] - c0), 64'd0);
    chk("t6_dis_clear_bin", 64'(clr_seen[1] - c1), 64'd0);
    chk("t6_dis_ovr", 64'(ovr_seen[0] - o0), 64'd0);
    chk("t6_dis_busy", 64'(busy[0]), 64'd0);
    enable = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      trigger = ($urandom_range(0, 29) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      reset   = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 49) == 0) rmode = $urandom_range(1, 2);
      if ($urandom_range(0, 9) == 0) begin
        timestamp = {$urandom(), $urandom()};
        pulses    = 48'({$urandom(), $urandom()});
      end
      cyc(1);
    end
    trigger = 1'b0;
    reset   = 1'b0;
    enable  = 1'b1;
    rmode   = 1;
    wait_idle(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
